// File: rtl/dds_pkg.sv
// Shared definitions for the DDS voice-engine slice.
//   state_t   : scheduler FSM encoding (2 bits)
//   M_DEFAULT : default operand width for the sample-by-gain multiply
package dds_pkg;

  localparam int M_DEFAULT = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req   : request vector, one bit per requester
//   last  : index granted most recently; scanning starts just after it
//   grant : one-hot grant (all zero when no request)
//   idx   : encoded index of the granted requester (0 when no request)
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  logic           found;
  logic [IDW-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // last itself is visited last, so the previous winner has lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last) + k) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one start/done sequential multiplier between N_REQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake; ready is a one-hot accept pulse
//   req_a, req_b        : packed operands, requester i at [i*M +: M]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_data    : requester index and product (0 on error)
//   rsp_err             : multiplier did not answer within TIMEOUT cycles
//   mul_start           : one-cycle start pulse to the external multiplier
//   mul_a, mul_b        : operands, held from accept until the next accept
//   mul_done, mul_p     : completion pulse and product from the multiplier
module mult_scheduler
  import dds_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int M       = M_DEFAULT,
  parameter int TIMEOUT = 31,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*M-1:0] req_a,
  input  logic [N_REQ*M-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [2*M-1:0]     rsp_data,
  output logic               rsp_err,
  output logic               mul_start,
  output logic [M-1:0]       mul_a,
  output logic [M-1:0]       mul_b,
  input  logic               mul_done,
  input  logic [2*M-1:0]     mul_p
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state, state_nx;
  logic [IDW-1:0]   last_grant;
  logic [CW-1:0]    wait_cnt;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_req;
  logic             timeout_hit;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign any_req     = |req_valid;
  // The counter reaches TIMEOUT on this edge, i.e. TIMEOUT full WAIT cycles.
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  // Gated by rst_n so every output reads 0 while reset is held, even with
  // requests pending.
  assign req_ready = (state == S_IDLE && rst_n) ? grant : '0;
  assign mul_start = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (mul_done || timeout_hit) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(N_REQ - 1);
      wait_cnt   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            mul_a  <= req_a[grant_idx*M +: M];
            mul_b  <= req_b[grant_idx*M +: M];
            rsp_id <= grant_idx;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // done is tested first so it wins over a simultaneous timeout.
          if (mul_done) begin
            rsp_data <= mul_p;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        S_RESP: if (rsp_ready) last_grant <= rsp_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
module tb_mult_scheduler;

  localparam int N_REQ   = 4;
  localparam int M       = 12;
  localparam int TIMEOUT = 31;
  localparam int IDW     = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ*M-1:0] req_a = '0;
  logic [N_REQ*M-1:0] req_b = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [IDW-1:0]     rsp_id;
  logic [2*M-1:0]     rsp_data;
  logic               rsp_err;
  logic               mul_start;
  logic [M-1:0]       mul_a;
  logic [M-1:0]       mul_b;
  logic               mul_done;
  logic [2*M-1:0]     mul_p;

  mult_scheduler #(.N_REQ(N_REQ), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_p     (mul_p)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: done pulse M+2 cycles after the start pulse.
  logic           mul_dead  = 1'b0;
  logic           late_done = 1'b0;
  int             m_cnt;
  logic [M-1:0]   m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      mul_done <= 1'b0;
      mul_p    <= '0;
    end else begin
      mul_done <= 1'b0;
      if (late_done) begin
        mul_done <= 1'b1;
        mul_p    <= 24'd1234;
      end else if (mul_start) begin
        m_cnt <= M + 1;
        m_a   <= mul_a;
        m_b   <= mul_b;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !mul_dead) begin
          mul_done <= 1'b1;
          mul_p    <= {12'b0, m_a} * {12'b0, m_b};
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expectation pushed on accept, compared on response handshake.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2*M-1:0] data;
    logic           err;
  } rsp_t;

  rsp_t             exp_q[$];
  int               grant_log[$];
  logic [N_REQ-1:0] acc = '0;
  int               start_cnt = 0;
  int               issue_cyc = 0;
  logic [2*M-1:0]   last_data = '0;
  int               g;
  logic [M-1:0]     ga, gb;
  rsp_t             e;

  always @(negedge clk) begin
    if (mul_start) begin
      start_cnt++;
      issue_cyc = cyc;
    end
    if (req_ready != '0) begin
      check("ready_onehot", $countones(req_ready), 1);
      g = 0;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
      check("ready_has_valid", req_valid[g], 1);
      ga = req_a[g*M +: M];
      gb = req_b[g*M +: M];
      grant_log.push_back(g);
      acc[g] = 1'b1;
      e.id   = IDW'(g);
      e.err  = mul_dead;
      e.data = mul_dead ? '0 : {12'b0, ga} * {12'b0, gb};
      exp_q.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        last_data = rsp_data;
      end
    end
  end

  // Requester models: job counts and current operands per requester.
  int           jobs[N_REQ];
  logic [M-1:0] cur_a[N_REQ];
  logic [M-1:0] cur_b[N_REQ];

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i]      = (jobs[i] > 0);
      req_a[i*M +: M]   = cur_a[i];
      req_b[i*M +: M]   = cur_b[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i]) begin
        acc[i]   = 1'b0;
        jobs[i]  = jobs[i] - 1;
        cur_a[i] = 12'($urandom_range(0, 4095));
        cur_b[i] = 12'($urandom_range(0, 4095));
      end
    end
    drive();
  endtask

  function automatic bit busy();
    bit b = (exp_q.size() != 0) || rsp_valid;
    for (int i = 0; i < N_REQ; i++) if (jobs[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(rsp_valid), 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) jobs[i] = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    grant_log.delete();
    acc   = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      jobs[i]  = 0;
      cur_a[i] = '0;
      cur_b[i] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    rst_n = 1'b1;

    // 1: single job from requester 0 right after reset.
    cur_a[0] = 12'd3;
    cur_b[0] = 12'd5;
    jobs[0]  = 1;
    start_cnt = 0;
    drive();
    @(negedge clk);
    check("t1_first_ready", 32'(req_ready), 32'b0001);
    wait_idle("t1_done", 100);
    check("t1_data", 32'(last_data), 15);
    check("t1_start_pulses", start_cnt, 1);

    // 2: all four requesters continuously valid, two jobs each.
    reset_dut();
    for (int i = 0; i < N_REQ; i++) begin
      jobs[i]  = 2;
      cur_a[i] = 12'($urandom_range(0, 4095));
      cur_b[i] = 12'($urandom_range(0, 4095));
    end
    drive();
    wait_idle("t2_done", 400);
    check("t2_grant_count", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size(); k++) check("t2_grant_order", grant_log[k], k % N_REQ);

    // 3: full-scale operands, no truncation of the 24-bit product.
    grant_log.delete();
    cur_a[2] = 12'd4095;
    cur_b[2] = 12'd4095;
    jobs[2]  = 1;
    drive();
    wait_idle("t3_done", 100);
    check("t3_data", 32'(last_data), 32'h00FF_E001);

    // 4: response back-pressure for 10 cycles.
    grant_log.delete();
    rsp_ready = 1'b0;
    jobs[0] = 1;
    jobs[3] = 1;
    drive();
    wait_rsp("t4_rsp_seen", 100);
    begin
      logic [2*M-1:0] held;
      held = rsp_data;
      repeat (10) begin
        step();
        check("t4_valid_held", 32'(rsp_valid), 1);
        check("t4_data_held", 32'(rsp_data), 32'(held));
        check("t4_no_ready", 32'(req_ready), 0);
      end
    end
    rsp_ready = 1'b1;
    wait_idle("t4_done", 200);
    check("t4_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t4_first_grant", grant_log[0], 3);
      check("t4_second_grant", grant_log[1], 0);
    end

    // 5: multiplier never answers; then a late done is ignored.
    grant_log.delete();
    mul_dead  = 1'b1;
    rsp_ready = 1'b0;
    jobs[1]   = 1;
    drive();
    wait_rsp("t5_rsp_seen", 100);
    check("t5_timeout_latency", cyc - issue_cyc, TIMEOUT + 1);
    check("t5_err", 32'(rsp_err), 1);
    check("t5_data", 32'(rsp_data), 0);
    late_done = 1'b1;
    step();
    late_done = 1'b0;
    step();
    step();
    check("t5_late_done_valid", 32'(rsp_valid), 1);
    check("t5_late_done_err", 32'(rsp_err), 1);
    check("t5_late_done_data", 32'(rsp_data), 0);
    rsp_ready = 1'b1;
    wait_idle("t5_done", 50);
    late_done = 1'b1;
    step();
    late_done = 1'b0;
    repeat (3) step();
    check("t5_idle_ignores_done", 32'(rsp_valid), 0);
    mul_dead = 1'b0;

    // 6: reset during WAIT aborts silently; requester 0 regains priority.
    grant_log.delete();
    jobs[2] = 1;
    drive();
    begin
      int n = 0;
      while (!mul_start && n < 50) begin
        step();
        n++;
      end
      check("t6_started", 32'(mul_start), 1);
    end
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_mul_start", 32'(mul_start), 0);
    check("t6_async_mul_a", 32'(mul_a), 0);
    check("t6_async_rsp_valid", 32'(rsp_valid), 0);
    check("t6_async_req_ready", 32'(req_ready), 0);
    for (int i = 0; i < N_REQ; i++) jobs[i] = 0;
    exp_q.delete();
    grant_log.delete();
    acc = '0;
    drive();
    repeat (3) begin
      @(negedge clk);
      check("t6_no_rsp_in_reset", 32'(rsp_valid), 0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("t6_no_rsp_after_abort", 32'(rsp_valid), 0);
    end
    @(posedge clk);
    #1;
    jobs[0] = 1;
    jobs[3] = 1;
    drive();
    wait_idle("t6_done", 200);
    check("t6_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t6_first_grant", grant_log[0], 0);
      check("t6_second_grant", grant_log[1], 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
